// File: rtl/mod113_stream_arb.sv
// mod113_stream_arb: two-requester frame arbiter that reduces each frame of 28-bit words to their sum mod 113.
// Define MOD113_RR_EN for round-robin arbitration; the default build uses fixed priority (requester 0 wins).
module mod113_stream_arb #(
   parameter int MAX_WORDS = 18
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  in_valid,
   input  logic [55:0] in_data,
   input  logic [1:0]  in_last,
   output logic [1:0]  in_ready,
   output logic        res_valid,
   output logic [6:0]  res_data,
   output logic        res_id,
   output logic        res_ovf,
   input  logic        res_ready,
   output logic        busy
);

   localparam int CW = $clog2(MAX_WORDS + 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_grant;
   logic [6:0]      r_acc;
   logic [CW-1:0]   r_count;
   logic            r_ovf;

   logic            w_grant_sel;
   logic            w_hs;
   logic            w_last;
   logic            w_cap;
   logic [27:0]     w_word;
   logic [6:0]      w_word_mod;
   logic [7:0]      w_sum;
   logic [6:0]      w_acc_nxt;

   // 2^7, 2^14, 2^21 are 15, 112, 98 mod 113; repeated digit folds shrink the value below 226.
   function automatic logic [6:0] word_mod113(input logic [27:0] w);
      logic [14:0] s1;
      logic [11:0] s2;
      logic [8:0]  s3;
      logic [7:0]  s4;
      s1 = 15'(w[6:0]) + 15'(w[13:7]) * 15'd15 + 15'(w[20:14]) * 15'd112 + 15'(w[27:21]) * 15'd98;
      s2 = 12'(s1[6:0]) + 12'(s1[13:7]) * 12'd15 + (s1[14] ? 12'd112 : 12'd0);
      s3 = 9'(s2[6:0]) + 9'(s2[11:7]) * 9'd15;
      s4 = 8'(s3[6:0]) + 8'(s3[8:7]) * 8'd15;
      return (s4 >= 8'd113) ? 7'(s4 - 8'd113) : s4[6:0];
   endfunction

   assign w_word     = r_grant ? in_data[55:28] : in_data[27:0];
   assign w_word_mod = word_mod113(w_word);
   assign w_sum      = {1'b0, r_acc} + {1'b0, w_word_mod};
   assign w_acc_nxt  = (w_sum >= 8'd113) ? 7'(w_sum - 8'd113) : w_sum[6:0];
   assign w_hs       = (r_state == S_BUSY) && in_valid[r_grant];
   assign w_last     = in_last[r_grant];
   assign w_cap      = (r_count == CW'(MAX_WORDS - 1));

`ifdef MOD113_RR_EN
   logic r_ptr;

   // Pointer only matters when both request together; a lone requester always wins.
   always_comb begin
      w_grant_sel = in_valid[1] & ~in_valid[0];
      if (in_valid == 2'b11) w_grant_sel = r_ptr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 1'b0;
      end else if (r_state == S_DONE && res_ready) begin
         r_ptr <= ~r_grant;
      end
   end
`else
   always_comb begin
      w_grant_sel = ~in_valid[0];
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 2'b00;
      res_valid   = 1'b0;
      res_data    = 7'd0;
      res_id      = 1'b0;
      res_ovf     = 1'b0;
      busy        = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (|in_valid) w_state_nxt = S_BUSY;
         end
         S_BUSY: begin
            in_ready = r_grant ? 2'b10 : 2'b01;
            if (w_hs && (w_last || w_cap)) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            res_valid = 1'b1;
            res_data  = r_acc;
            res_id    = r_grant;
            res_ovf   = r_ovf;
            if (res_ready) w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant <= 1'b0;
         r_acc   <= 7'd0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (r_state == S_IDLE && (|in_valid)) begin
         r_grant <= w_grant_sel;
         r_acc   <= 7'd0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (w_hs) begin
         r_acc   <= w_acc_nxt;
         r_count <= r_count + CW'(1);
         // Cut frame: the requester's remaining words open a fresh frame later.
         if (w_cap && !w_last) r_ovf <= 1'b1;
      end
   end

endmodule
